jtframe_sdadc_decim: RTL

- Receive-side counterpart of the 1-bit sigma-delta audio DAC, running in the same clk_dac domain with the same clock-enable rate.
- Accepts an external 1-bit oversampled bitstream, for example a comparator or cassette/line-in modulator pin.
- A third-order CIC decimator turns that bitstream into OUTW-bit PCM samples, each flagged by a one-cycle strobe.
- Output feeds the core's audio-in or tape-in logic.

---
 rtl/jtframe_sdadc_decim.sv | 105 ++++++++++
 1 files changed

// File: rtl/jtframe_sdadc_decim.sv
// Third-order CIC decimator for a 1-bit sigma-delta input stream.
// Produces OUTW-bit PCM samples, each marked by a one-cycle strobe.
module jtframe_sdadc_decim #(
  parameter int   DECW       = 6,
  parameter int   OUTW       = 16,
  parameter logic SIGNED_OUT = 1'b1
) (
  input  logic            rst,
  input  logic            clk_dac,
  input  logic            cen,
  input  logic            en,
  input  logic            din,
  output logic [OUTW-1:0] pcm,
  output logic            pcm_stb,
  output logic            valid,
  output logic            clip
);

  localparam int W  = 3*DECW+2;
  localparam int SW = 3*DECW+1;
  localparam logic signed [W-1:0] SAT_MAX  = {2'b00, {(3*DECW){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN  = {2'b11, {(3*DECW){1'b0}}};
  localparam logic [OUTW-1:0]     PCM_RST  = {~SIGNED_OUT, {(OUTW-1){1'b0}}};
  localparam logic [DECW-1:0]     CNT_LAST = {DECW{1'b1}};

  logic                din_meta, din_sync;
  logic signed [W-1:0] x, int1, int2, int3, dly1, dly2, dly3;
  logic signed [W-1:0] comb1, comb2, comb3, sat;
  logic [DECW-1:0]     cnt;
  logic [1:0]          settle;
  logic                dec_ev, over, under;
  logic [OUTW-1:0]     pcm_next;

  // din is asynchronous; the synchroniser runs free of cen and en
  always_ff @(posedge clk_dac) begin
    din_meta <= din;
    din_sync <= din_meta;
  end

  always_comb begin
    x        = din_sync ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    dec_ev   = cen && (cnt == CNT_LAST);
    comb1    = int3  - dly1;
    comb2    = comb1 - dly2;
    comb3    = comb2 - dly3;
    over     = comb3 > SAT_MAX;
    under    = comb3 < SAT_MIN;
    sat      = over ? SAT_MAX : (under ? SAT_MIN : comb3);
    // PCM_RST doubles as the MSB flip mask for offset-binary output
    pcm_next = sat[SW-1 -: OUTW] ^ PCM_RST;
  end

  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      int1    <= '0;
      int2    <= '0;
      int3    <= '0;
      dly1    <= '0;
      dly2    <= '0;
      dly3    <= '0;
      cnt     <= '0;
      settle  <= '0;
      pcm     <= PCM_RST;
      pcm_stb <= 1'b0;
      valid   <= 1'b0;
      clip    <= 1'b0;
    end else if (!en) begin
      int1    <= '0;
      int2    <= '0;
      int3    <= '0;
      dly1    <= '0;
      dly2    <= '0;
      dly3    <= '0;
      cnt     <= '0;
      settle  <= '0;
      pcm     <= PCM_RST;
      pcm_stb <= 1'b0;
      valid   <= 1'b0;
      clip    <= 1'b0;
    end else begin
      pcm_stb <= 1'b0;
      if (cen) begin
        int1 <= int1 + x;
        int2 <= int2 + int1;
        int3 <= int3 + int2;
        cnt  <= cnt + DECW'(1);
      end
      if (dec_ev) begin
        dly1 <= int3;
        dly2 <= comb1;
        dly3 <= comb2;
        // the comb memory holds start-up garbage for the first three events
        if (settle != 2'd3) begin
          settle <= settle + 2'd1;
        end else begin
          pcm     <= pcm_next;
          pcm_stb <= 1'b1;
          valid   <= 1'b1;
          if (over) clip <= 1'b1;
        end
      end
    end
  end

endmodule
